operand_issuer: RTL and testbench

Initiator side of the operand/result stable-ack handshake used by the arithmetic controller. Accepts one job (operand A, operand B, 3-bit opcode) from an upstream valid/ready port, delivers the three words to the controller with a four-phase stable/ack handshake, collects the 32-bit result the same way, and presents it downstream with an error flag. Sits between the job source (test sequencer or host FIFO) and the controller's input_a/input_b/input_op/output_z pins.

---
 rtl/calc_pkg.sv | 36 +++
 rtl/operand_issuer.sv | 138 +++++++++++++
 tb/tb_operand_issuer.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/calc_pkg.sv
// Shared definitions for the arithmetic-controller front end.
//
// Contents:
//   DATA_W / OP_W   operand word width and opcode width
//   OP_*            opcode encodings. The issuer only passes these through.
//   issuer_state_e  sequencing states of operand_issuer
//   is_wait_state   true for states that wait on a handshake edge from the
//                   controller. Only these states run the timeout counter.
package calc_pkg;

  localparam int DATA_W = 32;
  localparam int OP_W   = 3;

  localparam logic [OP_W-1:0] OP_ADD = 3'b000;
  localparam logic [OP_W-1:0] OP_SUB = 3'b001;
  localparam logic [OP_W-1:0] OP_MUL = 3'b010;
  localparam logic [OP_W-1:0] OP_DIV = 3'b011;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_A_REQ,
    ST_A_REL,
    ST_B_REQ,
    ST_B_REL,
    ST_OP_REQ,
    ST_OP_REL,
    ST_Z_WAIT,
    ST_Z_REL,
    ST_RESULT
  } issuer_state_e;

  function automatic logic is_wait_state(input issuer_state_e st);
    return (st != ST_IDLE) && (st != ST_RESULT);
  endfunction

endpackage

// File: rtl/operand_issuer.sv
// operand_issuer: the initiator side of the operand/result four-phase
// stable/ack handshake used by the arithmetic controller.
//
// The block accepts one job (A, B, opcode) on a valid/ready port. It sends A,
// then B, then the opcode, each with a four-phase stable/ack handshake. It then
// collects the result with the same protocol and presents the result
// downstream on a valid/ready port together with an abort flag.
//
// Ports:
//   clk, rst_n                     clock; asynchronous active-low reset
//   job_valid/job_ready            upstream job handshake
//   job_a, job_b, job_op           job payload. Latched when the job is accepted.
//   out_a/out_a_stable/in_a_ack    operand A channel to the controller
//   out_b/out_b_stable/in_b_ack    operand B channel to the controller
//   out_op/out_op_stable/in_op_ack opcode channel to the controller
//   in_z/in_z_stable/out_z_ack     result channel from the controller
//   res_valid/res_ready            downstream result handshake
//   res_z, res_err                 captured result; res_err=1 means timeout abort
//
// Parameter TIMEOUT_CYCLES sets the number of cycles allowed in a single wait
// state before the job is aborted. A value of 0 disables the timeout.
module operand_issuer
  import calc_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              job_valid,
  output logic              job_ready,
  input  logic [DATA_W-1:0] job_a,
  input  logic [DATA_W-1:0] job_b,
  input  logic [OP_W-1:0]   job_op,
  output logic [DATA_W-1:0] out_a,
  output logic              out_a_stable,
  input  logic              in_a_ack,
  output logic [DATA_W-1:0] out_b,
  output logic              out_b_stable,
  input  logic              in_b_ack,
  output logic [OP_W-1:0]   out_op,
  output logic              out_op_stable,
  input  logic              in_op_ack,
  input  logic [DATA_W-1:0] in_z,
  input  logic              in_z_stable,
  output logic              out_z_ack,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_z,
  output logic              res_err
);

  localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);

  issuer_state_e     state_q, state_d;
  logic [31:0]       cnt_q, cnt_d;
  logic              timeout;
  logic              job_ready_q, a_stable_q, b_stable_q, op_stable_q;
  logic              z_ack_q, res_valid_q, res_err_q;
  logic [DATA_W-1:0] a_q, b_q, res_z_q;
  logic [OP_W-1:0]   op_q;

  // Next-state logic. A timeout in any wait state overrides the normal transition.
  always_comb begin
    state_d = state_q;
    timeout = (TIMEOUT_CYCLES != 0) && is_wait_state(state_q) && (cnt_q == TO_LAST);
    unique case (state_q)
      ST_IDLE:   if (job_valid && job_ready_q) state_d = ST_A_REQ;
      ST_A_REQ:  if (in_a_ack)                 state_d = ST_A_REL;
      ST_A_REL:  if (!in_a_ack)                state_d = ST_B_REQ;
      ST_B_REQ:  if (in_b_ack)                 state_d = ST_B_REL;
      ST_B_REL:  if (!in_b_ack)                state_d = ST_OP_REQ;
      ST_OP_REQ: if (in_op_ack)                state_d = ST_OP_REL;
      ST_OP_REL: if (!in_op_ack)               state_d = ST_Z_WAIT;
      ST_Z_WAIT: if (in_z_stable)              state_d = ST_Z_REL;
      ST_Z_REL:  if (!in_z_stable)             state_d = ST_RESULT;
      ST_RESULT: if (res_valid_q && res_ready) state_d = ST_IDLE;
      default:                                 state_d = ST_IDLE;
    endcase
    if (timeout) state_d = ST_RESULT;

    // The counter measures time spent in the current wait state only.
    cnt_d = (state_d != state_q || !is_wait_state(state_q)) ? 32'd0 : cnt_q + 32'd1;
  end

  // The outputs are registered from the next state. Each stable/ack flag
  // therefore changes on the same edge that moves the FSM. At most one flag
  // can be high at a time, because at most one state is current.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      job_ready_q <= 1'b0;
      a_stable_q  <= 1'b0;
      b_stable_q  <= 1'b0;
      op_stable_q <= 1'b0;
      z_ack_q     <= 1'b0;
      res_valid_q <= 1'b0;
      res_err_q   <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      res_z_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      job_ready_q <= (state_d == ST_IDLE);
      a_stable_q  <= (state_d == ST_A_REQ);
      b_stable_q  <= (state_d == ST_B_REQ);
      op_stable_q <= (state_d == ST_OP_REQ);
      z_ack_q     <= (state_d == ST_Z_REL);
      res_valid_q <= (state_d == ST_RESULT);
      if (state_q == ST_IDLE && state_d == ST_A_REQ) begin
        a_q       <= job_a;
        b_q       <= job_b;
        op_q      <= job_op;
        res_err_q <= 1'b0;
      end
      if (state_q == ST_Z_WAIT && state_d == ST_Z_REL) res_z_q <= in_z;
      if (timeout) begin
        res_z_q   <= '0;
        res_err_q <= 1'b1;
      end
    end
  end

  assign job_ready     = job_ready_q;
  assign out_a         = a_q;
  assign out_a_stable  = a_stable_q;
  assign out_b         = b_q;
  assign out_b_stable  = b_stable_q;
  assign out_op        = op_q;
  assign out_op_stable = op_stable_q;
  assign out_z_ack     = z_ack_q;
  assign res_valid     = res_valid_q;
  assign res_z         = res_z_q;
  assign res_err       = res_err_q;

endmodule

// File: tb/tb_operand_issuer.sv
// Testbench for operand_issuer.
//
// A behavioural controller responds to each stable signal: it raises the ack
// ack_dly+1 samples after stable rises, and drops it 2 samples after stable
// falls. It returns the result once the opcode handshake has completed. A
// monitor records the order in which the stable signals rise, how long each
// stays high, any overlap between them, and any change of operand data while
// a job is in flight.
module tb_operand_issuer;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        job_valid = 1'b0, job_ready;
  logic [31:0] job_a = '0, job_b = '0;
  logic [2:0]  job_op = '0;
  logic [31:0] out_a, out_b, res_z;
  logic [2:0]  out_op;
  logic        out_a_stable, out_b_stable, out_op_stable, out_z_ack;
  logic        in_a_ack = 1'b0, in_b_ack = 1'b0, in_op_ack = 1'b0;
  logic        zs_resp = 1'b0, z_glitch = 1'b0;
  logic [31:0] zval = '0;
  logic        res_valid, res_ready = 1'b0, res_err;

  int ncmp = 0, nfail = 0;
  logic [32:0] sbq[$];

  // responder controls
  int ack_dly = 1;
  bit b_mute = 1'b0;

  // monitor results
  int overlap_cnt = 0, data_chg = 0, a_len = 0, b_len = 0, op_len = 0;
  int order[$];
  logic [31:0] a_at_rise, b_at_rise;
  logic [2:0]  op_at_rise;

  always #5 clk = ~clk;

  operand_issuer #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .job_valid(job_valid), .job_ready(job_ready),
    .job_a(job_a), .job_b(job_b), .job_op(job_op),
    .out_a(out_a), .out_a_stable(out_a_stable), .in_a_ack(in_a_ack),
    .out_b(out_b), .out_b_stable(out_b_stable), .in_b_ack(in_b_ack),
    .out_op(out_op), .out_op_stable(out_op_stable), .in_op_ack(in_op_ack),
    .in_z(z_glitch ? 32'hDEAD_BEEF : zval), .in_z_stable(zs_resp | z_glitch),
    .out_z_ack(out_z_ack),
    .res_valid(res_valid), .res_ready(res_ready), .res_z(res_z), .res_err(res_err)
  );

  // controller model
  initial begin : responder
    int ca, cb, co, zc;
    logic z_pend, tgt;
    ca = 0; cb = 0; co = 0; zc = 0; z_pend = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        in_a_ack = 1'b0; in_b_ack = 1'b0; in_op_ack = 1'b0; zs_resp = 1'b0;
        z_pend = 1'b0; ca = 0; cb = 0; co = 0; zc = 0;
      end else begin
        if (z_pend && !zs_resp && !out_z_ack) begin
          zc++; if (zc > 1) begin zs_resp = 1'b1; zc = 0; end
        end else if (zs_resp && out_z_ack) begin
          zc++; if (zc > 1) begin zs_resp = 1'b0; z_pend = 1'b0; zc = 0; end
        end else zc = 0;
        tgt = out_a_stable;
        if (tgt != in_a_ack) begin
          ca++; if (ca > (tgt ? ack_dly : 1)) begin in_a_ack = tgt; ca = 0; end
        end else ca = 0;
        tgt = out_b_stable && !b_mute;
        if (tgt != in_b_ack) begin
          cb++; if (cb > (tgt ? ack_dly : 1)) begin in_b_ack = tgt; cb = 0; end
        end else cb = 0;
        tgt = out_op_stable;
        if (tgt != in_op_ack) begin
          co++;
          if (co > (tgt ? ack_dly : 1)) begin
            if (!tgt) z_pend = 1'b1;
            in_op_ack = tgt; co = 0;
          end
        end else co = 0;
      end
    end
  end

  initial begin : monitor
    logic pa, pb, po, pjr;
    logic [31:0] pda, pdb;
    logic [2:0]  pdo;
    pa = 0; pb = 0; po = 0; pjr = 0; pda = '0; pdb = '0; pdo = '0;
    forever begin
      @(posedge clk); #1;
      if (rst_n) begin
        if (32'(out_a_stable) + 32'(out_b_stable) + 32'(out_op_stable) > 1) overlap_cnt++;
        if (out_a_stable && !pa) begin order.push_back(0); a_at_rise = out_a; a_len = 0; end
        if (out_b_stable && !pb) begin order.push_back(1); b_at_rise = out_b; b_len = 0; end
        if (out_op_stable && !po) begin order.push_back(2); op_at_rise = out_op; op_len = 0; end
        if (out_a_stable) a_len++;
        if (out_b_stable) b_len++;
        if (out_op_stable) op_len++;
        if (!job_ready && !pjr && (out_a != pda || out_b != pdb || out_op != pdo)) data_chg++;
      end
      pa = out_a_stable; pb = out_b_stable; po = out_op_stable; pjr = job_ready;
      pda = out_a; pdb = out_b; pdo = out_op;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    order.delete();
    data_chg = 0;
  endtask

  // Drive a job and push its expected result when the job is accepted.
  task automatic send_job(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                          input logic [31:0] ez, input logic eerr);
    int n;
    job_a = a; job_b = b; job_op = op; job_valid = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!job_ready && n < 100);
    chk("accept_wait", 32'(job_ready), 32'd1);
    @(posedge clk); #1;
    job_valid = 1'b0;
    sbq.push_back({eerr, ez});
  endtask

  // Wait for res_valid and compare the result against the scoreboard.
  task automatic wait_res(output int lat);
    logic [32:0] e;
    lat = 0;
    while (!res_valid && lat < 200) begin @(posedge clk); #1; lat++; end
    chk("res_wait", 32'(res_valid), 32'd1);
    if (res_valid) begin
      chk("sb_nonempty", 32'(sbq.size() > 0), 32'd1);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("res_z", res_z, e[31:0]);
        chk("res_err", 32'(res_err), 32'(e[32]));
      end
    end
  endtask

  task automatic ack_res();
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
  endtask

  initial begin : main
    int lat, holds, seen;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    // reset state
    chk("rst_ctrl", 32'({job_ready, out_a_stable, out_b_stable, out_op_stable,
                          out_z_ack, res_valid, res_err}), 32'd0);
    chk("rst_data", out_a | out_b | res_z | 32'(out_op), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_ready", 32'(job_ready), 32'd1);

    // zero-wait job. Accept E0; 4 edges per word; result stable at E13, ack at
    // E14, release seen at E16. res_valid is therefore observed 16 edges after
    // accept (18 cycles counting the accept and RESULT cycles).
    clear_mon(); zval = 32'h4040_0000;
    send_job(32'h3F80_0000, 32'h4000_0000, 3'd0, 32'h4040_0000, 1'b0);
    chk("a_rise_1cyc", 32'(out_a_stable), 32'd1);
    wait_res(lat);
    chk("latency", 32'(lat), 32'd16);
    chk("order", (order.size() == 3) ? 32'(order[0] * 100 + order[1] * 10 + order[2]) : 32'd999, 32'd12);
    chk("a_data", a_at_rise, 32'h3F80_0000);
    chk("b_data", b_at_rise, 32'h4000_0000);
    chk("op_data", 32'(op_at_rise), 32'd0);
    chk("a_len0", 32'(a_len), 32'd2);
    ack_res();
    chk("ready_after", 32'(job_ready), 32'd1);

    // responder delays each ack by 5 cycles
    clear_mon(); ack_dly = 5; zval = 32'h1234_5678;
    send_job(32'hAAAA_5555, 32'h0F0F_F0F0, 3'd5, 32'h1234_5678, 1'b0);
    wait_res(lat);
    chk("a_len5", 32'(a_len), 32'd6);
    chk("b_len5", 32'(b_len), 32'd6);
    chk("op_len5", 32'(op_len), 32'd6);
    chk("data_hold", 32'(data_chg), 32'd0);
    chk("b_data5", b_at_rise, 32'h0F0F_F0F0);
    chk("op_data5", 32'(op_at_rise), 32'd5);
    ack_res();
    ack_dly = 1;

    // B never acknowledged: abort after TO cycles
    clear_mon(); b_mute = 1'b1; zval = 32'h7777_7777;
    send_job(32'h1111_1111, 32'h2222_2222, 3'd2, 32'h0, 1'b1);
    wait_res(lat);
    chk("to_b_len", 32'(b_len), 32'(TO));
    chk("to_no_op", 32'(order.size()), 32'd2);
    chk("to_b_drop", 32'({out_a_stable, out_b_stable, out_op_stable, out_z_ack}), 32'd0);
    ack_res();
    b_mute = 1'b0;
    chk("err_kept_idle", 32'(res_err), 32'd1);

    // downstream stalls 10 cycles, then a back-to-back job
    clear_mon(); zval = 32'hCAFE_F00D;
    send_job(32'h0000_0001, 32'h0000_0002, 3'd7, 32'hCAFE_F00D, 1'b0);
    chk("err_cleared", 32'(res_err), 32'd0);
    wait_res(lat);
    holds = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (res_valid && res_z == 32'hCAFE_F00D && !job_ready) holds++;
    end
    chk("stall_hold", 32'(holds), 32'd10);
    job_a = 32'h5A5A_0000; job_b = 32'h0000_A5A5; job_op = 3'd3; job_valid = 1'b1;
    ack_res();
    chk("b2b_ready", 32'({job_ready, res_valid}), 32'b10);
    @(posedge clk); #1;
    chk("b2b_accept", 32'(job_ready), 32'd0);
    chk("b2b_out_a", out_a, 32'h5A5A_0000);
    job_valid = 1'b0;
    zval = 32'h0BAD_F00D;
    sbq.push_back({1'b0, 32'h0BAD_F00D});
    wait_res(lat);
    ack_res();

    // asynchronous reset during B_REQ
    clear_mon();
    send_job(32'h3333_3333, 32'h4444_4444, 3'd1, 32'h0, 1'b0);
    seen = 0;
    while (!out_b_stable && seen < 50) begin @(posedge clk); #1; seen++; end
    chk("reach_b_req", 32'(out_b_stable), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_hs", 32'({out_a_stable, out_b_stable, out_op_stable, out_z_ack, job_ready}), 32'd0);
    chk("arst_data", out_a, 32'd0);
    sbq.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    holds = 0;
    repeat (20) begin @(posedge clk); #1; if (res_valid) holds++; end
    chk("arst_no_res", 32'(holds), 32'd0);
    chk("arst_ready", 32'(job_ready), 32'd1);

    // in_z_stable pulse during A_REQ is ignored
    clear_mon(); ack_dly = 4; zval = 32'h600D_600D;
    send_job(32'h8000_0000, 32'h7FFF_FFFF, 3'd6, 32'h600D_600D, 1'b0);
    z_glitch = 1'b1;
    @(posedge clk); #1;
    z_glitch = 1'b0;
    chk("glitch_in_a_req", 32'(out_a_stable), 32'd1);
    holds = 0;
    repeat (3) begin @(posedge clk); #1; if (out_z_ack) holds++; end
    chk("glitch_no_ack", 32'(holds), 32'd0);
    wait_res(lat);
    ack_res();
    ack_dly = 1;

    // every opcode encoding passes through unchanged
    for (int op = 0; op < 8; op++) begin
      clear_mon(); zval = 32'h100 + 32'(op);
      send_job(32'(op) << 4, 32'(op) << 8, 3'(op), 32'h100 + 32'(op), 1'b0);
      wait_res(lat);
      chk("op_pass", 32'(op_at_rise), 32'(op));
      ack_res();
    end

    chk("no_overlap", 32'(overlap_cnt), 32'd0);
    chk("sb_drained", 32'(sbq.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
